// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Width of a requester id; never narrower than one bit.
  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester bundle plus FIFO write-side pins; slave modport is the arbiter's view.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ*WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]       req_last_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic                   fifo_full_i;
  logic                   fifo_push_o;
  logic [ID_W+WIDTH-1:0]  fifo_data_o;

  modport master (
    output req_valid_i, req_data_i, req_last_i, fifo_full_i,
    input  req_ready_o, fifo_push_o, fifo_data_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, fifo_full_i,
    output req_ready_o, fifo_push_o, fifo_data_o
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: lowest request at or above ptr, else lowest overall.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_idx_o,
  output logic             any_gnt_o
);
  logic [ID_W-1:0] m_idx_s;
  logic [ID_W-1:0] u_idx_s;
  logic            m_any_s;
  logic            m_hit_s;

  // Scanning downward leaves the lowest matching index in each search result.
  always_comb begin
    m_idx_s = {ID_W{1'b0}};
    u_idx_s = {ID_W{1'b0}};
    m_any_s = 1'b0;
    m_hit_s = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      m_hit_s = req_i[i] & (ID_W'(i) >= ptr_i);
      m_idx_s = m_hit_s ? ID_W'(i) : m_idx_s;
      m_any_s = m_any_s | m_hit_s;
      u_idx_s = req_i[i] ? ID_W'(i) : u_idx_s;
    end
    any_gnt_o = |req_i;
    gnt_idx_o = m_any_s ? m_idx_s : u_idx_s;
    gnt_o     = any_gnt_o ? (N_REQ'(1'b1) << gnt_idx_o) : {N_REQ{1'b0}};
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; 1-entry registered output stage.
// Optional burst locking is enabled by defining FIFO_ARB_LOCK_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int ID_W = id_width(N_REQ);
  localparam int DW   = ID_W + WIDTH;

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  lock_id_q, lock_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;

  logic [N_REQ-1:0] arb_req_s;
  logic [N_REQ-1:0] gnt_s;
  logic [ID_W-1:0]  gnt_idx_s;
  logic             any_gnt_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             push_s;
  logic             stage_free_s;
  logic             accept_s;
  logic [N_REQ-1:0] ready_s;

  assign arb_req_s = (state_q == LOCK) ? (bus.req_valid_i & (N_REQ'(1'b1) << lock_id_q))
                                       : bus.req_valid_i;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req_i     (arb_req_s),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s),
    .any_gnt_o (any_gnt_s)
  );

  assign sel_data_s = bus.req_data_i[gnt_idx_s*WIDTH +: WIDTH];

  // Gating with rstn_i keeps a held beat from leaking out during the reset cycle.
  always_comb begin
    push_s       = rstn_i & out_valid_q & ~bus.fifo_full_i;
    stage_free_s = ~out_valid_q | push_s;
    accept_s     = rstn_i & any_gnt_s & stage_free_s;
    ready_s      = accept_s ? gnt_s : {N_REQ{1'b0}};
  end

  assign bus.req_ready_o = ready_s;
  assign bus.fifo_push_o = push_s;
  assign bus.fifo_data_o = out_data_q;

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
`ifdef FIFO_ARB_LOCK_EN
    case (state_q)
      ARB: begin
        if (accept_s && !bus.req_last_i[gnt_idx_s]) begin
          state_d   = LOCK;
          lock_id_d = gnt_idx_s;
        end else begin
          state_d   = ARB;
        end
      end
      LOCK: begin
        if (accept_s && bus.req_last_i[lock_id_q]) begin
          state_d = ARB;
        end else begin
          state_d = LOCK;
        end
      end
      default: state_d = ARB;
    endcase
`else
    state_d = ARB;
`endif
  end

`ifndef FIFO_ARB_LOCK_EN
  logic unused_last_s;
  assign unused_last_s = ^bus.req_last_i;
`endif

  // Pointer moves past the winner only when the beat leaves us in ARB.
  always_comb begin
    if (accept_s && (state_d == ARB)) begin
      rr_ptr_d = (gnt_idx_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : gnt_idx_s + ID_W'(1'b1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = {gnt_idx_s, sel_data_s};
    end else if (push_s) begin
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end else begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= ARB;
      lock_id_q <= {ID_W{1'b0}};
      rr_ptr_q  <= {ID_W{1'b0}};
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {DW{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: cycle model + scoreboard, directed cases, random run into a depth-10 FIFO model.
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DW    = 10;
  localparam int DEPTH = 10;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int seq[N];
  int next_pop[N];
  int m_ptr, m_lock;
  bit m_ov, m_locked, m_zero, use_fifo, pop_en;
  int dut_g;
  logic [N-1:0] dut_rdy;
  logic dut_push;
  int n_acc, n_pop;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] beat(input int id, input int s);
    logic [1:0] idb;
    logic [7:0] pay;
    idb = 2'(id);
    pay = 8'(id * 64 + (s % 64));
    return {idb, pay};
  endfunction

  task automatic drive_data();
    for (int i = 0; i < N; i++) bus.req_data_i[i*W +: W] = W'(i * 64 + (seq[i] % 64));
  endtask

  task automatic step();
    int g;
    int id;
    logic [N-1:0] v;
    logic [N-1:0] exp_rdy;
    logic [DW-1:0] item;
    bit exp_push, free, acc;
    @(negedge clk);
    dut_rdy  = bus.req_ready_o;
    dut_push = bus.fifo_push_o;
    dut_g    = -1;
    for (int i = 0; i < N; i++) if (dut_rdy[i]) dut_g = i;
    exp_push = rstn && m_ov && !bus.fifo_full_i;
    free     = !m_ov || exp_push;
    v        = bus.req_valid_i;
    if (m_locked) v = v & (N'(1) << m_lock);
    g        = pick(v, m_ptr);
    acc      = rstn && (g >= 0) && free;
    exp_rdy  = acc ? (N'(1) << g) : N'(0);
    check_eq("ready", 32'(dut_rdy), 32'(exp_rdy));
    check_eq("push", 32'(dut_push), 32'(exp_push));
    if (m_ov) check_eq("data", 32'(bus.fifo_data_o), 32'(exp_q[0]));
    if (m_zero) check_eq("rst_data", 32'(bus.fifo_data_o), 32'd0);
    if (use_fifo && pop_en && fifo_q.size() > 0) begin
      item = fifo_q.pop_front();
      id   = int'(item[9:8]);
      check_eq("pop_id", 32'(item[7:6]), 32'(item[9:8]));
      check_eq("pop_order", 32'(item[5:0]), 32'(next_pop[id] % 64));
      next_pop[id]++;
      n_pop++;
    end
    if (use_fifo && dut_push) begin
      fifo_q.push_back(bus.fifo_data_o);
      check_eq("fifo_ovf", 32'(fifo_q.size() <= DEPTH), 32'd1);
    end
    if (!rstn) begin
      m_ov = 1'b0; m_ptr = 0; m_locked = 1'b0; m_lock = 0; m_zero = 1'b1;
      exp_q.delete();
    end else begin
      if (exp_push) begin
        void'(exp_q.pop_front());
        m_ov = 1'b0;
      end
      if (acc) begin
        exp_q.push_back(beat(g, seq[g]));
        m_ov = 1'b1;
        m_zero = 1'b0;
        n_acc++;
`ifdef FIFO_ARB_LOCK_EN
        if (!m_locked && !bus.req_last_i[g]) begin
          m_locked = 1'b1;
          m_lock = g;
        end else if (m_locked && bus.req_last_i[g]) begin
          m_locked = 1'b0;
        end
`endif
        if (!m_locked) m_ptr = (g + 1) % N;
        seq[g]++;
      end
    end
    @(posedge clk);
    #1;
    if (use_fifo) bus.fifo_full_i = (fifo_q.size() >= DEPTH);
    drive_data();
  endtask

  initial begin
    int exp1[5] = '{0, 1, 2, 3, 0};
    int exp2[3] = '{2, 0, 2};
    int exp5[4] = '{1, 1, 1, 2};
    int budget;
    bus.req_valid_i = 4'b0000;
    bus.req_last_i  = 4'b1111;
    bus.fifo_full_i = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    m_ov = 1'b0; m_ptr = 0; m_locked = 1'b0; m_lock = 0; m_zero = 1'b0;
    use_fifo = 1'b0; pop_en = 1'b0;
    drive_data();

    repeat (3) step();
    rstn = 1'b1;
    step();

    bus.req_valid_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("t1_grant", 32'(dut_g), 32'(exp1[k]));
    end

    bus.req_valid_i = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("t2_grant", 32'(dut_g), 32'(exp2[k]));
      check_eq("t2_mask", 32'(dut_rdy & 4'b1010), 32'd0);
    end

    bus.req_valid_i = 4'b1111;
    step();
    check_eq("t3_load", 32'(dut_g), 32'd3);
    bus.fifo_full_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("t3_ready", 32'(dut_rdy), 32'd0);
      check_eq("t3_nopush", 32'(dut_push), 32'd0);
      check_eq("t3_hold", 32'(bus.fifo_data_o), 32'h3C1);
    end
    bus.fifo_full_i = 1'b0;
    step();
    check_eq("t3_push", 32'(dut_push), 32'd1);
    check_eq("t3_resume", 32'(dut_g), 32'd0);

    bus.req_valid_i = 4'b0000;
    bus.fifo_full_i = 1'b1;
    step();
    rstn = 1'b0;
    step();
    check_eq("t4_rst_push", 32'(dut_push), 32'd0);
    rstn = 1'b1;
    bus.fifo_full_i = 1'b0;
    step();
    check_eq("t4_nostale", 32'(dut_push), 32'd0);
    bus.req_valid_i = 4'b1111;
    step();
    check_eq("t4_ptr", 32'(dut_g), 32'd0);

`ifdef FIFO_ARB_LOCK_EN
    bus.req_valid_i = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      bus.req_last_i = (k == 2) ? 4'b0111 : 4'b0101;
      step();
      check_eq("t5_lock", 32'(dut_g), 32'(exp5[k]));
    end
    bus.req_last_i = 4'b1111;
`else
    exp5[0] = 0;
`endif

    bus.req_valid_i = 4'b0000;
    repeat (2) step();

    use_fifo = 1'b1;
    n_acc = 0;
    n_pop = 0;
    fifo_q.delete();
    for (int i = 0; i < N; i++) next_pop[i] = seq[i];
    for (int c = 0; c < 400; c++) begin
      bus.req_valid_i = 4'($urandom);
      bus.req_last_i  = 4'($urandom);
      pop_en = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step();
    end
    bus.req_valid_i = 4'b0000;
    pop_en = 1'b1;
    budget = 0;
    while ((fifo_q.size() > 0 || m_ov) && budget < 50) begin
      step();
      budget++;
    end
    check_eq("drain_timeout", 32'(budget < 50), 32'd1);
    check_eq("beat_count", 32'(n_pop), 32'(n_acc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
